// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP constants, FSM state type and MWr32 header word builder
// for the ECP3 16-bit VC0 transmit path.
package pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_D    = 3'b010;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;
  localparam int         HDR_WORDS    = 6;
  localparam int         CREDIT_SHIFT = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_REQ,
    S_HDR,
    S_DATA
  } tx_state_e;

  // 3DW MWr header as six 16-bit words; dw_addr is byte address [31:2].
  function automatic logic [15:0] mwr32_hdr_word(
    input logic [2:0]  idx,
    input logic [9:0]  len,
    input logic [29:0] dw_addr,
    input logic [15:0] rid
  );
    logic [15:0] w;
    case (idx)
      3'd0:    w = {FMT_3DW_D, TYPE_MEM, 8'h00};
      3'd1:    w = {6'b0, len};
      3'd2:    w = rid;
      3'd3:    w = {8'h00, (len == 10'd1) ? 4'h0 : 4'hF, 4'hF};
      3'd4:    w = dw_addr[29:14];
      3'd5:    w = {dw_addr[13:0], 2'b00};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tlp_mwr_tx_if.sv
// Request/payload side and ECP3 tx_*_vc0 side of the MWr transmitter.
interface tlp_mwr_tx_if #(
  parameter int LEN_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic [29:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic [15:0]      data_in;
  logic             data_rd;
  logic             tx_req;
  logic             tx_rdy;
  logic             tx_st;
  logic             tx_end;
  logic [15:0]      tx_data;
  logic [8:0]       tx_ca_ph;
  logic [12:0]      tx_ca_pd;
  logic             tx_ca_p_recheck;

  modport master (
    input  req_valid, req_addr, req_len, data_in,
    input  tx_rdy, tx_ca_ph, tx_ca_pd, tx_ca_p_recheck,
    output req_ready, data_rd, tx_req, tx_st, tx_end, tx_data
  );

  modport slave (
    output req_valid, req_addr, req_len, data_in,
    output tx_rdy, tx_ca_ph, tx_ca_pd, tx_ca_p_recheck,
    input  req_ready, data_rd, tx_req, tx_st, tx_end, tx_data
  );
endinterface

// File: rtl/tlp_credit_chk.sv
// Posted credit check: one header credit plus ceil(len/4) data credits,
// either of which may be advertised as infinite.
module tlp_credit_chk
  import pcie_tlp_pkg::*;
#(
  parameter int LEN_W = 10
) (
  input  logic [8:0]       i_ph,
  input  logic [12:0]      i_pd,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_pass
);
  localparam int SW = LEN_W + 1;

  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_pdc;
  logic          w_ph_ok;
  logic          w_pd_ok;

  assign w_sum   = {1'b0, i_len} + SW'(3);
  assign w_pdc   = w_sum >> CREDIT_SHIFT;
  assign w_ph_ok = i_ph[8] | (i_ph[7:0] != 8'd0);
  assign w_pd_ok = i_pd[12] | (i_pd[11:0] >= 12'(w_pdc));
  assign o_pass  = w_ph_ok & w_pd_ok;

endmodule

// File: rtl/tlp_mwr_tx.sv
// MWr32 TLP transmitter: latches a write request, waits for posted credits,
// requests the link and streams a 6-word header followed by 2*len payload words.
module tlp_mwr_tx
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_DW = 32,
  parameter int LEN_W  = 10
) (
  input  logic         clk_125,
  input  logic         rstn,
  input  logic [7:0]   bus_num,
  input  logic [4:0]   dev_num,
  input  logic [2:0]   func_num,
  tlp_mwr_tx_if.master tx_if,
  output logic         busy,
  output logic         err_len,
  output logic [15:0]  tlp_cnt
);
  localparam int CNT_W = 11;

  tx_state_e        r_state;
  logic             r_req_ready;
  logic             r_tx_req;
  logic             r_tx_st;
  logic             r_tx_end;
  logic             r_data_ph;
  logic             r_err_len;
  logic [15:0]      r_tx_data;
  logic [15:0]      r_tlp_cnt;
  logic [15:0]      r_rid;
  logic [29:0]      r_addr;
  logic [LEN_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;

  logic             w_hs;
  logic             w_len_bad;
  logic             w_pass;
  logic [15:0]      w_hdr0;
  logic [15:0]      w_hdr_next;

  assign w_hs       = tx_if.req_valid & r_req_ready & (r_state == S_IDLE);
  assign w_len_bad  = (tx_if.req_len == '0) | (tx_if.req_len > LEN_W'(MAX_DW));
  assign w_hdr0     = mwr32_hdr_word(3'd0, r_len[9:0], r_addr, r_rid);
  assign w_hdr_next = mwr32_hdr_word(r_cnt[2:0] + 3'd1, r_len[9:0], r_addr, r_rid);

  tlp_credit_chk #(.LEN_W(LEN_W)) u_credit_chk (
    .i_ph   (tx_if.tx_ca_ph),
    .i_pd   (tx_if.tx_ca_pd),
    .i_len  (r_len),
    .o_pass (w_pass)
  );

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_tx_req    <= 1'b0;
      r_tx_st     <= 1'b0;
      r_tx_end    <= 1'b0;
      r_data_ph   <= 1'b0;
      r_err_len   <= 1'b0;
      r_tx_data   <= '0;
      r_tlp_cnt   <= '0;
      r_rid       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_last      <= '0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_hs) begin
            r_addr <= tx_if.req_addr;
            r_len  <= tx_if.req_len;
            r_rid  <= {bus_num, dev_num, func_num};
            r_last <= CNT_W'(HDR_WORDS - 1) + CNT_W'({tx_if.req_len, 1'b0});
            if (w_len_bad) begin
              r_err_len <= 1'b1;
            end else begin
              r_req_ready <= 1'b0;
              r_state     <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (w_pass) begin
            r_tx_req <= 1'b1;
            r_state  <= S_REQ;
          end
        end
        S_REQ: begin
          // A recheck in the grant cycle wins: credits may have just shrunk.
          if (tx_if.tx_ca_p_recheck) begin
            r_tx_req <= 1'b0;
            r_state  <= S_CHK;
          end else if (tx_if.tx_rdy) begin
            r_tx_req  <= 1'b0;
            r_tx_st   <= 1'b1;
            r_tx_data <= w_hdr0;
            r_cnt     <= '0;
            r_state   <= S_HDR;
          end
        end
        S_HDR: begin
          r_tx_st <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(HDR_WORDS - 1)) begin
            r_data_ph <= 1'b1;
            r_tx_data <= '0;
            r_state   <= S_DATA;
          end else begin
            r_tx_data <= w_hdr_next;
          end
        end
        S_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == r_last) begin
            r_data_ph   <= 1'b0;
            r_tx_end    <= 1'b0;
            r_tlp_cnt   <= r_tlp_cnt + 16'd1;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_tx_end <= ((r_cnt + 1'b1) == r_last);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload passes straight from the FWFT head so the pop and the word coincide.
  assign tx_if.tx_data   = r_data_ph ? tx_if.data_in : r_tx_data;
  assign tx_if.data_rd   = r_data_ph;
  assign tx_if.req_ready = r_req_ready;
  assign tx_if.tx_req    = r_tx_req;
  assign tx_if.tx_st     = r_tx_st;
  assign tx_if.tx_end    = r_tx_end;
  assign busy            = (r_state != S_IDLE);
  assign err_len         = r_err_len;
  assign tlp_cnt         = r_tlp_cnt;

endmodule
